// File: rtl/sideband_req_responder.sv
// sideband_req_responder
// Responder for the 4-phase sideband req/ack channel. It accepts one data word
// per request pulse into a small fall-through FIFO and presents queued words
// to core logic over valid/ready.
// Build option: define SIDEBAND_RSP_SYNC_EN to put a 2-flop synchronizer on
// sb_req, for a sender that runs asynchronously to clk. Without it, sb_req is
// used directly and the sender must be synchronous to clk.
module sideband_req_responder #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sb_req,
  input  logic [DW-1:0]            sb_data,
  output logic                     sb_ack,
  output logic                     out_valid,
  output logic [DW-1:0]            out_data,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [15:0]              rx_cnt
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {IDLE = 1'b0, ACK = 1'b1} state_t;

  logic              req_s;
  state_t            state_reg;
  state_t            state_next;
  logic              push;
  logic              pop;
  logic              full;
  logic [AW-1:0]     wr_ptr_reg;
  logic [AW-1:0]     rd_ptr_reg;
  logic [AW:0]       count_reg;
  logic [AW:0]       count_next;
  logic [15:0]       rx_cnt_reg;
  logic [DW-1:0]     mem [DEPTH];

`ifdef SIDEBAND_RSP_SYNC_EN
  logic [1:0] sync_reg;

  // Two-flop synchronizer bringing the asynchronous request into the clk domain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_reg <= 2'b00;
    else     sync_reg <= {sync_reg[0], sb_req};
  end

  assign req_s = sync_reg[1];
`else
  assign req_s = sb_req;
`endif

  // Full uses the registered count, so a pop in the same cycle does not
  // open a slot for a waiting request until the following cycle.
  assign full      = (count_reg == (AW+1)'(DEPTH));
  assign out_valid = (count_reg != '0);
  assign pop       = out_valid && out_ready;
  assign out_data  = mem[rd_ptr_reg];
  assign sb_ack    = (state_reg == ACK);
  assign fifo_level = count_reg;
  assign rx_cnt    = rx_cnt_reg;

  // Handshake state register; reset drops sb_ack without waiting for a clock
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic: a single push on entry to ACK, so a long request
  // cannot be captured twice; a full FIFO holds the sender in IDLE.
  always_comb begin
    state_next = state_reg;
    push       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req_s && !full) begin
          push       = 1'b1;
          state_next = ACK;
        end
      end
      ACK: begin
        if (!req_s) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Storage array; contents need no reset because count gates visibility
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= sb_data;
  end

  // Occupancy for the coming cycle; push and pop together leave it unchanged
  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + (AW+1)'(1);
      2'b01:   count_next = count_reg - (AW+1)'(1);
      default: count_next = count_reg;
    endcase
  end

  // FIFO pointers and count; pointers wrap naturally at DEPTH
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_next;
    end
  end

  // Accepted-transfer counter, wraps from 0xFFFF to 0x0000
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       rx_cnt_reg <= 16'h0000;
    else if (push) rx_cnt_reg <= rx_cnt_reg + 16'h0001;
  end

endmodule

// File: doc/sideband_req_responder.md
# sideband_req_responder

DUT-side responder for the sideband 4-phase request/acknowledge channel driven by the sideband agent. It synchronizes the incoming request, captures the accompanying data word into a small FIFO, and completes the handshake. It then presents captured words to core logic over a valid/ready interface. It sits at the chip boundary between the sideband pins and internal control logic.

## Interface
- `DW`, 8: sideband data width in bits.
- `DEPTH`, 4: FIFO depth in words; power of two, ≥2.
- `clk` input 1: single clock; all logic on rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `sb_req` input 1: sideband request; asynchronous to `clk` when sync is compiled in.
- `sb_data` input DW: sideband data; stable while `sb_req`=1 until `sb_ack`=1.
- `sb_ack` output 1: sideband acknowledge, registered.
- `out_valid` output 1: FIFO non-empty.
- `out_data` output DW: FIFO head word, fall-through.
- `out_ready` input 1: consumer accepts head when `out_valid`=1.
- `fifo_level` output $clog2(DEPTH)+1: current occupancy.
- `rx_cnt` output 16: accepted-transfer counter; wraps 0xFFFF→0x0000.

## Operation
- `req_s` is the internal request: `sb_req` after the synchronizer, or raw `sb_req` (see Configuration).
- FSM has two states, IDLE and ACK. Reset state is IDLE.
  - IDLE, `req_s`=1 and not full: push `sb_data` into FIFO, `rx_cnt`+1, `sb_ack`←1, go to ACK.
  - IDLE, `req_s`=1 and full: stay in IDLE with `sb_ack`=0. This stalls the sender (backpressure). No drop, no count.
  - IDLE, `req_s`=0: stay.
  - ACK, `req_s`=0: `sb_ack`←0, go to IDLE.
  - ACK, `req_s`=1: stay with `sb_ack`=1.
- Exactly one push per request pulse, regardless of how long `req_s` stays high.
- Full is evaluated on the registered count before any same-cycle pop. There is no full-bypass: a request arriving while full waits one cycle after a pop frees a slot.
- FIFO:
  - Pointers are $clog2(DEPTH) bits wide and wrap naturally.
  - The count is one bit wider.
  - Push and pop in the same cycle (not full, not empty): level unchanged, both pointers advance.
  - Pop when empty is ignored.
- `out_data` is undefined when `out_valid`=0. The bench must not check it then.
- Reset values: `sb_ack`=0, `out_valid`=0, `fifo_level`=0, `rx_cnt`=0. Pointers are 0 and synchronizer flops are 0.
- Reset mid-transfer:
  - FIFO contents are discarded and `sb_ack` drops immediately (async).
  - If `sb_req` is still 1 after reset release, it is treated as a new request and accepted again.
  - Resolving the resulting duplicate is the sender's responsibility.

## Timing
- With sync:
  - `sb_req` rising before edge N gives `req_s`=1 after edge N+1.
  - Push and `sb_ack`=1 occur after edge N+2.
  - `sb_req` fall to `sb_ack` fall takes the same 3 edges.
- Without sync:
  - `sb_ack` rises on the first edge where `sb_req`=1 and not full.
  - `sb_ack` falls on the first edge where `sb_req`=0.
- `sb_data` is sampled on the push edge. The protocol guarantees it is stable for at least 2 cycles before that edge when sync is compiled in.
- `out_valid` rises the cycle after the push edge, and `fifo_level` updates on the same edge.
- Pop takes effect on the edge where `out_valid`&&`out_ready`; the next word appears combinationally.
- Minimum handshake period is 6 `clk` cycles with sync and 2 cycles without.

## Configuration
- `SIDEBAND_RSP_SYNC_EN`
  - Defined: a 2-flop synchronizer (reset to 0) sits on `sb_req`. Use this when the sender is asynchronous.
  - Undefined: `req_s` = `sb_req` directly. Use this only when the sender is synchronous to `clk`; latency is per the no-sync figures above.

## Test plan
- **Single transfer (sync on):**
  - Stimulus: `sb_data`=0xA5, raise `sb_req` and hold `out_ready`=0.
  - Response: `sb_ack`=1 exactly 3 edges later; `fifo_level`=1, `out_data`=0xA5, `rx_cnt`=1; after `sb_req` falls, `sb_ack`=0 3 edges later.
- **Backpressure:**
  - Stimulus: DEPTH=4, 5 transfers with `out_ready`=0.
  - Response: 4 acks, 5th `sb_req` held with `sb_ack`=0, `rx_cnt`=4; pulse `out_ready` one cycle, then the 5th acks, `fifo_level`=4, `rx_cnt`=5.
- **Long request:**
  - Stimulus: hold `sb_req`=1 for 50 cycles.
  - Response: exactly one push, `rx_cnt`=1.
- **Simultaneous push/pop:**
  - Stimulus: `fifo_level`=2 with `out_ready`=1 on the push edge.
  - Response: `fifo_level` stays 2 and FIFO order is preserved.
- **Reset mid-op:**
  - Stimulus: assert `rst` while in ACK with 3 words queued.
  - Response: `sb_ack`, `out_valid`, `fifo_level` and `rx_cnt` are 0 without waiting for a clock edge; `sb_req` held high after release is re-accepted (`rx_cnt`=1).
- **Counter wrap (sync off):**
  - Stimulus: preload 0xFFFF transfers, then one more.
  - Response: `rx_cnt`=0x0000; `sb_ack` latency is 1 edge.
